// File: rtl/riscv_pipe_chain.sv
// Elastic DEPTH-stage valid/ready register chain with an input skid entry,
// bubble collapsing, per-stage flush, global hold and per-stage forwarding taps.
module riscv_pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  input  logic [DEPTH-1:0]           i_flush,
  input  logic                       i_hold,
  output logic [DEPTH-1:0]           o_stage_valid,
  output logic [DEPTH*WIDTH-1:0]     o_stage_data,
  output logic [$clog2(DEPTH+2)-1:0] o_count
);
  localparam int CountW = $clog2(DEPTH + 2);

  logic [DEPTH-1:0] stageValid;
  logic [WIDTH-1:0] stageData [DEPTH];
  logic             skidValid;
  logic [WIDTH-1:0] skidData;
  logic [DEPTH-1:0] adv;
  logic             inXfer;
  logic             srcValid;
  logic [WIDTH-1:0] srcData;

  // Stage k may advance when any stage at or beyond k is empty, or the consumer
  // takes the head; this is the adv[k] = ~v[k] | adv[k+1] recurrence unrolled,
  // which keeps the ripple out of a self-referencing vector.
  for (genvar k = 0; k < DEPTH; k++) begin : gAdv
    assign adv[k] = i_ready | ~(&stageValid[DEPTH-1:k]);
  end

  // Ready depends only on registered state and hold, never on i_ready.
  assign o_ready  = ~skidValid & ~i_hold;
  assign inXfer   = i_valid & o_ready;
  assign srcValid = skidValid | inXfer;
  assign srcData  = skidValid ? skidData : i_data;

  // NOTE: the payload array is reset along with the valids so the taps read
  // zeros out of reset rather than X; flush deliberately leaves data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stageValid <= '0;
      skidValid  <= 1'b0;
      skidData   <= '0;
      for (int k = 0; k < DEPTH; k++) stageData[k] <= '0;
    end else begin
      // NOTE: every state register uses non-blocking assignment so all stages
      // sample the pre-edge values of their neighbours.
      if (i_flush[0]) begin
        skidValid <= 1'b0;
      end else if (!i_hold) begin
        if (skidValid && adv[0]) begin
          skidValid <= 1'b0;
        end else if (inXfer && !adv[0]) begin
          skidValid <= 1'b1;
          skidData  <= i_data;
        end
      end

      if (i_flush[0]) begin
        stageValid[0] <= 1'b0;
      end else if (!i_hold && adv[0]) begin
        stageValid[0] <= srcValid;
        if (srcValid) stageData[0] <= srcData;
      end

      for (int k = 1; k < DEPTH; k++) begin
        if (i_flush[k]) begin
          stageValid[k] <= 1'b0;
        end else if (!i_hold && adv[k]) begin
          stageValid[k] <= stageValid[k-1];
          if (stageValid[k-1]) stageData[k] <= stageData[k-1];
        end
      end
    end
  end

  // NOTE: o_count is assigned before the loop so the block is fully specified
  // on every path and no latch is inferred; blocking '=' lets the sum accumulate.
  always_comb begin
    o_count = CountW'(skidValid);
    for (int k = 0; k < DEPTH; k++) o_count = o_count + CountW'(stageValid[k]);
  end

  assign o_valid       = stageValid[DEPTH-1] & ~i_hold;
  assign o_data        = stageData[DEPTH-1];
  assign o_stage_valid = stageValid;

  for (genvar k = 0; k < DEPTH; k++) begin : gTap
    assign o_stage_data[k*WIDTH +: WIDTH] = stageData[k];
  end

endmodule
